// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
// Request/grant handshake between the stage managers and the bus arbiter.
//
//   req          managers -> arbiter  level request, one bit per manager
//   done         managers -> arbiter  release strobe, one bit per manager
//   grant        arbiter  -> managers registered one-hot grant (0 = no owner)
//   grant_id     arbiter  -> managers index of the current owner (0 = no owner)
//   is_bus_busy  arbiter  -> managers bus owned or in turnaround
//   timeout_err  arbiter  -> managers one-cycle pulse on watchdog reclaim
//
// Modports: master = arbiter side, slave = manager side.
// ---------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic            is_bus_busy;
  logic            timeout_err;

  modport master (
    input  req,
    input  done,
    output grant,
    output grant_id,
    output is_bus_busy,
    output timeout_err
  );

  modport slave (
    output req,
    output done,
    input  grant,
    input  grant_id,
    input  is_bus_busy,
    input  timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the shared CPU memory bus. One manager owns the bus
// at a time; every change of owner passes through a single idle turnaround
// cycle so the released tristate drivers settle to z before the next owner
// drives. A watchdog reclaims the bus from an owner that holds it for more
// than TIMEOUT cycles (TIMEOUT = 0 disables the watchdog).
//
// Parameters: NREQ (2..8) requesters, ID_W with 2^ID_W >= NREQ,
//             TIMEOUT (0..255) maximum grant length in cycles.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  master modport of bus_arbiter_if (req/done in, grant/grant_id/
//        is_bus_busy/timeout_err out)
// The arbiter never drives addr/data; owners drive them while granted.
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  // Count value at which the watchdog fires: cnt is 0 during the first
  // granted cycle, so firing at TIMEOUT-1 caps the grant at TIMEOUT cycles.
  localparam logic [7:0] WD_LAST = 8'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit         WD_EN   = (TIMEOUT != 0);

  logic [1:0]      state;
  logic [NREQ-1:0] grant_q;
  logic [ID_W-1:0] grant_id_q;
  logic [ID_W-1:0] last_q;
  logic [7:0]      cnt_q;
  logic            timeout_err_q;

  logic            win_found;
  logic [NREQ-1:0] win_oh;
  logic [ID_W-1:0] win_id;

  logic            owner_req;
  logic            owner_done;
  logic            release_req;
  logic            wd_fire;

  // Round-robin pick: each requester gets a distance from last_q+1; the
  // nearest pending request wins. Indexing only with the loop constant keeps
  // the search a fixed priority mux over rotated distances.
  always_comb begin
    int best_off;
    int off;
    win_found = 1'b0;
    win_oh    = '0;
    win_id    = '0;
    best_off  = NREQ;
    off       = 0;
    for (int j = 0; j < NREQ; j++) begin
      off = (j - int'(last_q) - 1 + 2 * NREQ) % NREQ;
      if (bus.req[j] && (off < best_off)) begin
        best_off  = off;
        win_found = 1'b1;
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_id    = ID_W'(j);
      end
    end
  end

  // Only the owner's req/done matter; masking with the one-hot grant avoids
  // indexing by grant_id and ignores every non-owner bit for free.
  assign owner_req   = |(bus.req & grant_q);
  assign owner_done  = |(bus.done & grant_q);
  assign release_req = owner_done | ~owner_req;
  assign wd_fire     = WD_EN && (cnt_q == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      last_q        <= ID_W'(NREQ - 1);
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state)
        ST_IDLE, ST_TURN: begin
          if (win_found) begin
            grant_q    <= win_oh;
            grant_id_q <= win_id;
            last_q     <= win_id;
            cnt_q      <= '0;
            state      <= ST_GRANT;
          end else begin
            state      <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // A voluntary release takes precedence over the watchdog, so a
          // release on the final allowed cycle never raises timeout_err.
          if (release_req) begin
            grant_q    <= '0;
            grant_id_q <= '0;
            state      <= ST_TURN;
          end else if (wd_fire) begin
            grant_q       <= '0;
            grant_id_q    <= '0;
            timeout_err_q <= 1'b1;
            state         <= ST_TURN;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          grant_q    <= '0;
          grant_id_q <= '0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Busy decodes straight from the state register so it clears together
  // with the asynchronous reset.
  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.is_bus_busy = (state != ST_IDLE);
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  bus_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus  ();
  bus_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus0 ();

  bus_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bus_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  always #5 clk = ~clk;

  // {grant, grant_id, is_bus_busy, timeout_err}
  logic [7:0] outs;
  assign outs = {bus.grant, bus.grant_id, bus.is_bus_busy, bus.timeout_err};

  // -------------------------------------------------------------------------
  // Reference model: who owns the bus, whether a turnaround is pending, who
  // was served last and how long the current grant has lasted.
  // -------------------------------------------------------------------------
  typedef struct packed {
    bit has;
    int own;
    int last;
    int held;
    bit gap;
    bit err;
  } mstate_t;

  mstate_t m;

  function automatic logic bit_of(logic [NREQ-1:0] v, int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic mstate_t model_next(mstate_t s, logic [NREQ-1:0] rq,
                                         logic [NREQ-1:0] dn);
    mstate_t n;
    n = s;
    n.err = 1'b0;
    if (s.has) begin
      if (bit_of(dn, s.own) || !bit_of(rq, s.own)) begin
        n.has = 1'b0;
        n.gap = 1'b1;
      end else if (TO != 0 && s.held == TO) begin
        n.has = 1'b0;
        n.gap = 1'b1;
        n.err = 1'b1;
      end else begin
        n.held = s.held + 1;
      end
    end else begin
      n.gap = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!n.has && bit_of(rq, (s.last + k) % NREQ)) begin
          n.has  = 1'b1;
          n.own  = (s.last + k) % NREQ;
          n.last = n.own;
          n.held = 1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{has: 1'b0, own: 0, last: NREQ - 1, held: 0, gap: 1'b0, err: 1'b0};
    else     m <= model_next(m, bus.req, bus.done);
  end

  // grant must be one-hot matching grant_id, or zero with grant_id zero.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!(bus.grant === 4'b0000 && bus.grant_id === 2'd0) &&
          bus.grant !== (4'b0001 << bus.grant_id)) begin
        errors++;
        $display("FAIL onehot_id: grant=%b id=%0d, required one-hot of id or all zero",
                 bus.grant, bus.grant_id);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    bus.req   = '0;
    bus.done  = '0;
    bus0.req  = '0;
    bus0.done = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    repeat (2) @(negedge clk);
    exp = 8'h00;
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL reset_outputs: got %b want %b", outs, exp); end
    checks++;
    if ({bus0.grant, bus0.is_bus_busy} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs_t0: got %b want 00000", {bus0.grant, bus0.is_bus_busy});
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] exp;
    do_reset();
    bus.req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      exp = {4'b0001, 2'd0, 1'b1, 1'b0};
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL single_grant c%0d: got %b want %b", c, outs, exp); end
    end
    bus.done = 4'b0001;
    @(negedge clk);
    exp = {4'b0000, 2'd0, 1'b1, 1'b0};
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL single_turn: got %b want %b", outs, exp); end
    bus.done = '0;
    bus.req  = '0;
    @(negedge clk);
    exp = 8'h00;
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL single_idle: got %b want %b", outs, exp); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp;
    logic [3:0] g;
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      g   = 4'b0001 << (k % 4);
      exp = {g, ID_W'(k % 4), 1'b1, 1'b0};
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL rr_grant k%0d: got %b want %b", k, outs, exp); end
      bus.done = g;
      @(negedge clk);
      exp = {4'b0000, 2'd0, 1'b1, 1'b0};
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL rr_turn k%0d: got %b want %b", k, outs, exp); end
      bus.done = '0;
    end
    bus.req = '0;
    @(negedge clk);
    exp = 8'h00;
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL rr_idle: got %b want %b", outs, exp); end
  endtask

  task automatic test_fairness();
    logic [7:0] exp;
    do_reset();
    bus.req = 4'b0010;
    @(negedge clk);
    bus.done = 4'b0010;
    @(negedge clk);
    bus.done = '0;
    bus.req  = 4'b1001;
    @(negedge clk);
    exp = {4'b1000, 2'd3, 1'b1, 1'b0};
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL fair_skip_to3: got %b want %b", outs, exp); end
    bus.done = 4'b1000;
    @(negedge clk);
    bus.done = '0;
    bus.req  = 4'b0001;
    @(negedge clk);
    exp = {4'b0001, 2'd0, 1'b1, 1'b0};
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL fair_then0: got %b want %b", outs, exp); end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_watchdog();
    logic [7:0] exp;
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      exp = {4'b0100, 2'd2, 1'b1, 1'b0};
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL wd_hold c%0d: got %b want %b", c, outs, exp); end
    end
    @(negedge clk);
    exp = {4'b0000, 2'd0, 1'b1, 1'b1};
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL wd_pulse: got %b want %b", outs, exp); end
    @(negedge clk);
    exp = {4'b0100, 2'd2, 1'b1, 1'b0};
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL wd_regrant: got %b want %b", outs, exp); end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_done_on_final();
    logic [7:0] exp;
    do_reset();
    bus.req = 4'b0100;
    repeat (TO) @(negedge clk);
    bus.done = 4'b0100;
    @(negedge clk);
    exp = {4'b0000, 2'd0, 1'b1, 1'b0};
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL done_final_no_err: got %b want %b", outs, exp); end
    bus.done = '0;
    bus.req  = '0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    do_reset();
    bus.req = 4'b0110;
    @(negedge clk);
    bus.done = 4'b0100;
    @(negedge clk);
    exp = {4'b0010, 2'd1, 1'b1, 1'b0};
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL nonowner_done: got %b want %b", outs, exp); end
    bus.done = '0;
    bus.req  = 4'b0100;
    @(negedge clk);
    exp = {4'b0000, 2'd0, 1'b1, 1'b0};
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL req_drop_release: got %b want %b", outs, exp); end
    @(negedge clk);
    exp = {4'b0100, 2'd2, 1'b1, 1'b0};
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL pending_kept: got %b want %b", outs, exp); end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midgrant();
    logic [7:0] exp;
    do_reset();
    bus.req = 4'b0100;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp = 8'h00;
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL async_reset: got %b want %b", outs, exp); end
    bus.req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp = {4'b0001, 2'd0, 1'b1, 1'b0};
    checks++;
    if (outs !== exp) begin errors++; $display("FAIL reset_last: got %b want %b", outs, exp); end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_watchdog();
    int bad;
    do_reset();
    bus0.req = 4'b0100;
    @(negedge clk);
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (bus0.grant !== 4'b0100 || bus0.timeout_err !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL no_wd_hold: bad cycles %0d want 0", bad); end
    bus0.req = '0;
    @(negedge clk);
    checks++;
    if ({bus0.grant, bus0.is_bus_busy} !== 5'b00001) begin
      errors++; $display("FAIL no_wd_release: got %b want 00001", {bus0.grant, bus0.is_bus_busy});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] exp;
    logic [3:0] eg;
    logic [3:0] nr;
    logic [3:0] nd;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      eg  = m.has ? (4'b0001 << m.own) : 4'b0000;
      exp = {eg, (m.has ? ID_W'(m.own) : 2'd0), (m.has || m.gap), m.err};
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL random n%0d: got %b want %b", n, outs, exp); end
      nr = bus.req;
      for (int i = 0; i < NREQ; i++) begin
        if (!nr[i]) nr[i] = ($urandom_range(0, 99) < 40);
        else if ($urandom_range(0, 99) < 8) nr[i] = 1'b0;
        nd[i] = ($urandom_range(0, 99) < 12);
      end
      bus.req  = nr;
      bus.done = nd;
    end
    bus.req  = '0;
    bus.done = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    bus.req   = '0;
    bus.done  = '0;
    bus0.req  = '0;
    bus0.done = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_watchdog();
    test_done_on_final();
    test_simultaneous();
    test_reset_midgrant();
    test_no_watchdog();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
